warp_scheduler: RTL

Sequences warps through the shared fetch/decode/execute pipeline of one compute core. It drives `warp_state` into the decoder and the other pipeline stages, and time-multiplexes the single pipeline between up to `NUM_WARPS` warps in round-robin order. It also retires warps on HALT and implements the SYNC barrier across all live warps. It sits between the core's start/done control and the fetcher, decoder and LSU.

---
 rtl/warp_scheduler_pkg.sv | 21 ++
 rtl/warp_scheduler_rr_picker.sv | 28 ++
 rtl/warp_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler: pipeline stage and per-warp status encodings.
package warp_scheduler_pkg;

    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_REQUEST,
        WARP_WAIT,
        WARP_EXECUTE,
        WARP_UPDATE,
        WARP_DONE
    } warp_state_t;

    typedef enum logic [1:0] {
        READY,
        PARKED,
        RETIRED
    } warp_status_t;

endpackage

// File: rtl/warp_scheduler_rr_picker.sv
// Combinational round-robin search: first set mask bit at base+1, base+2, ..., base (mod NUM_WARPS).
module rr_picker #(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] mask,
    input  logic [WID_W-1:0]     base,
    output logic [WID_W-1:0]     sel,
    output logic                 found
);

    logic [WID_W-1:0] cand;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        // Index arithmetic wraps naturally since NUM_WARPS is a power of two.
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = base + WID_W'(i);
            if (!found && mask[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Time-multiplexes one fetch/decode/execute pipeline across live warps, with HALT
// retirement and an all-live-warps SYNC barrier.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WID_W:0]    warp_count,
    input  logic              fetch_valid,
    input  logic              decoded_halt,
    input  logic              decoded_sync,
    input  logic              decoded_mem_read_enable,
    input  logic              decoded_mem_write_enable,
    input  logic              lsu_done,
    output warp_state_t       warp_state,
    output logic [WID_W-1:0]  current_warp,
    output logic              pc_update,
    output logic              done
);

    warp_state_t                       state_q, state_d;
    logic [WID_W-1:0]                  cur_q, cur_d;
    logic                              pc_q, pc_d;
    logic                              done_q, done_d;
    warp_status_t [NUM_WARPS-1:0]      status_q, status_d, status_post;
    logic [NUM_WARPS-1:0]              rdy_mask, live_mask;
    logic [WID_W-1:0]                  rdy_sel, rel_sel;
    logic                              rdy_found, rel_found, any_parked;
    logic [WID_W:0]                    wc_clamp;
    logic                              do_select;

    assign warp_state   = state_q;
    assign current_warp = cur_q;
    assign pc_update    = pc_q;
    assign done         = done_q;

    assign wc_clamp = (warp_count > (WID_W+1)'(NUM_WARPS)) ? (WID_W+1)'(NUM_WARPS) : warp_count;

    // SELECT must see the current warp's HALT/SYNC outcome from this same cycle.
    always_comb begin
        status_post = status_q;
        if (state_q == WARP_REQUEST) begin
            if (decoded_halt)
                status_post[cur_q] = RETIRED;
            else if (decoded_sync)
                status_post[cur_q] = PARKED;
        end
    end

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_mask
        assign rdy_mask[g]  = (status_post[g] == READY);
        assign live_mask[g] = (status_post[g] != RETIRED);
    end

    assign any_parked = |(live_mask & ~rdy_mask);

    // The release pick treats every live warp as ready, which is exactly the post-barrier view.
    rr_picker #(.NUM_WARPS(NUM_WARPS), .WID_W(WID_W)) u_pick_ready (
        .mask  (rdy_mask),
        .base  (cur_q),
        .sel   (rdy_sel),
        .found (rdy_found)
    );

    rr_picker #(.NUM_WARPS(NUM_WARPS), .WID_W(WID_W)) u_pick_release (
        .mask  (live_mask),
        .base  (cur_q),
        .sel   (rel_sel),
        .found (rel_found)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pc_d      = 1'b0;
        done_d    = done_q;
        status_d  = status_q;
        do_select = 1'b0;

        case (state_q)
            WARP_IDLE: begin
                if (start) begin
                    cur_d  = '0;
                    done_d = 1'b0;
                    for (int i = 0; i < NUM_WARPS; i++)
                        status_d[i] = ((WID_W+1)'(i) < wc_clamp) ? READY : RETIRED;
                    if (wc_clamp == '0) begin
                        state_d = WARP_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WARP_FETCH;
                    end
                end
            end
            WARP_FETCH:   if (fetch_valid) state_d = WARP_DECODE;
            WARP_DECODE:  state_d = WARP_REQUEST;
            WARP_REQUEST: begin
                if (decoded_halt) begin
                    do_select = 1'b1;
                end else if (decoded_sync) begin
                    pc_d      = 1'b1;
                    do_select = 1'b1;
                end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                    state_d = WARP_WAIT;
                end else begin
                    state_d = WARP_EXECUTE;
                end
            end
            WARP_WAIT:    if (lsu_done) state_d = WARP_EXECUTE;
            WARP_EXECUTE: state_d = WARP_UPDATE;
            WARP_UPDATE: begin
                pc_d      = 1'b1;
                do_select = 1'b1;
            end
            WARP_DONE:    state_d = WARP_IDLE;
            default:      state_d = WARP_IDLE;
        endcase

        if (do_select) begin
            status_d = status_post;
            if (rdy_found) begin
                cur_d   = rdy_sel;
                state_d = WARP_FETCH;
            end else if (any_parked && rel_found) begin
                for (int i = 0; i < NUM_WARPS; i++)
                    if (status_post[i] == PARKED) status_d[i] = READY;
                cur_d   = rel_sel;
                state_d = WARP_FETCH;
            end else begin
                state_d = WARP_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WARP_IDLE;
            cur_q   <= '0;
            pc_q    <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++) status_q[i] <= RETIRED;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pc_q     <= pc_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

endmodule
